// File: rtl/wb_bus_arb.sv
// wb_bus_arb: round-robin arbiter for classic Wishbone masters with value/mask slave decode
// and error termination. Define WB_BUS_TIMEOUT_EN to add a slave-ack timeout counter.
module wb_bus_arb #(
  parameter int                 WB_DATA_WIDTH  = 8,
  parameter int                 WB_ADDR_WIDTH  = 16,
  parameter int                 NUM_MASTERS    = 2,
  parameter int                 NUM_SLAVES     = 3,
  parameter logic [WB_DATA_WIDTH-1:0] ERR_DATA = 8'hFF,
  parameter int                 TIMEOUT_CYCLES = 255
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic [NUM_MASTERS-1:0]             mstr_stb_i,
  input  logic [NUM_MASTERS-1:0]             mstr_we_i,
  input  logic [NUM_MASTERS*WB_ADDR_WIDTH-1:0] mstr_adr_i,
  input  logic [NUM_MASTERS*WB_DATA_WIDTH-1:0] mstr_dat_i,
  output logic [NUM_MASTERS-1:0]             mstr_ack_o,
  output logic [NUM_MASTERS-1:0]             mstr_err_o,
  output logic [WB_DATA_WIDTH-1:0]           mstr_dat_o,
  input  logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0] bus_slv_addr_decode_value,
  input  logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0] bus_slv_addr_decode_mask,
  output logic [NUM_SLAVES-1:0]              slv_stb_o,
  output logic [NUM_SLAVES-1:0]              slv_we_o,
  output logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0] slv_adr_o,
  output logic [NUM_SLAVES*WB_DATA_WIDTH-1:0] slv_dat_o,
  input  logic [NUM_SLAVES-1:0]              slv_ack_i,
  input  logic [NUM_SLAVES*WB_DATA_WIDTH-1:0] slv_dat_i,
  output logic [NUM_MASTERS-1:0]             grant_o,
  output logic [1:0]                         dbg_state_o
);

  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, ERR, DONE} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [MW-1:0]          gidx_q, gidx_d;
  logic [MW-1:0]          rr_q, rr_d;

  function automatic logic [MW-1:0] wrap_idx(input logic [MW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_MASTERS) s = s - NUM_MASTERS;
    return MW'(s);
  endfunction

  // Signals of the currently granted master.
  logic                     g_stb, g_we;
  logic [WB_ADDR_WIDTH-1:0] g_adr;
  logic [WB_DATA_WIDTH-1:0] g_dat;

  always_comb begin
    g_stb = mstr_stb_i[gidx_q];
    g_we  = mstr_we_i[gidx_q];
    g_adr = mstr_adr_i[gidx_q*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
    g_dat = mstr_dat_i[gidx_q*WB_DATA_WIDTH +: WB_DATA_WIDTH];
  end

  // Round-robin pick: smallest offset from the pointer wins, so scan downwards.
  logic          req_any;
  logic [MW-1:0] pick;

  always_comb begin
    req_any = |mstr_stb_i;
    pick    = rr_q;
    for (int k = NUM_MASTERS-1; k >= 0; k--) begin
      if (mstr_stb_i[wrap_idx(rr_q, k)]) pick = wrap_idx(rr_q, k);
    end
  end

  // Slave s occupies the vector slice NUM_SLAVES-1-s; scanning downwards lets slave 0 win.
  logic          hit;
  logic [SW-1:0] hit_b;

  always_comb begin
    hit   = 1'b0;
    hit_b = '0;
    for (int s = NUM_SLAVES-1; s >= 0; s--) begin
      if ((g_adr & bus_slv_addr_decode_mask[(NUM_SLAVES-1-s)*WB_ADDR_WIDTH +: WB_ADDR_WIDTH]) ==
          (bus_slv_addr_decode_value[(NUM_SLAVES-1-s)*WB_ADDR_WIDTH +: WB_ADDR_WIDTH] &
           bus_slv_addr_decode_mask[(NUM_SLAVES-1-s)*WB_ADDR_WIDTH +: WB_ADDR_WIDTH])) begin
        hit   = 1'b1;
        hit_b = SW'(NUM_SLAVES-1-s);
      end
    end
  end

  logic busy_ack;
  assign busy_ack = (state_q == BUSY) && g_stb && hit && slv_ack_i[hit_b];

  logic to_hit;
`ifdef WB_BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  logic [TW-1:0] to_cnt_q;

  // Counts BUSY cycles including the current one; fires on the last allowed cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                          to_cnt_q <= '0;
    else if (state_q == BUSY && !busy_ack) to_cnt_q <= to_cnt_q + 1'b1;
    else                                   to_cnt_q <= '0;
  end

  assign to_hit = (to_cnt_q == TW'(TIMEOUT_CYCLES-1));
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    rr_d       = rr_q;
    slv_stb_o  = '0;
    mstr_ack_o = '0;
    mstr_err_o = '0;
    mstr_dat_o = '0;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          state_d       = BUSY;
          gidx_d        = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
        end
      end
      BUSY: begin
        if (!g_stb) begin
          // Abort: no response, but the pointer still moves past this master.
          state_d = IDLE;
          grant_d = '0;
          rr_d    = wrap_idx(gidx_q, 1);
        end else if (!hit) begin
          state_d = ERR;
        end else begin
          slv_stb_o[hit_b] = 1'b1;
          mstr_dat_o       = slv_dat_i[hit_b*WB_DATA_WIDTH +: WB_DATA_WIDTH];
          if (busy_ack) begin
            mstr_ack_o[gidx_q] = 1'b1;
            state_d            = DONE;
            grant_d            = '0;
            rr_d               = wrap_idx(gidx_q, 1);
          end else if (to_hit) begin
            state_d = ERR;
          end
        end
      end
      ERR: begin
        mstr_err_o[gidx_q] = 1'b1;
        mstr_dat_o         = ERR_DATA;
        state_d            = DONE;
        grant_d            = '0;
        rr_d               = wrap_idx(gidx_q, 1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign slv_we_o    = {NUM_SLAVES{g_we}};
  assign slv_adr_o   = {NUM_SLAVES{g_adr}};
  assign slv_dat_o   = {NUM_SLAVES{g_dat}};
  assign grant_o     = grant_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_bus_arb.sv
// tb_wb_bus_arb: random masters and wait-state slaves against a transaction-level
// arbitration/decode model; covers WB_BUS_TIMEOUT_EN when that macro is defined.
module tb_wb_bus_arb;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int NM = 2;
  localparam int NS = 3;
`ifdef WB_BUS_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NM-1:0]    mstr_stb, mstr_we, mstr_ack, mstr_err, grant;
  logic [NM*AW-1:0] mstr_adr;
  logic [NM*DW-1:0] mstr_wdat;
  logic [DW-1:0]    mstr_rdat;
  logic [NS*AW-1:0] dec_val, dec_mask, slv_adr;
  logic [NS-1:0]    slv_stb, slv_we, slv_ack;
  logic [NS*DW-1:0] slv_wdat, slv_rdat;
  logic [1:0]       dbg_state;

  // Slave 0 RAM 0x00xx, slave 1 0x0xxx (overlaps RAM), slave 2 ROM 0xFxxx.
  assign dec_val  = {16'h0000, 16'h0000, 16'hF000};
  assign dec_mask = {16'hFF00, 16'hF000, 16'hF000};

  wb_bus_arb #(.WB_DATA_WIDTH(DW), .WB_ADDR_WIDTH(AW), .NUM_MASTERS(NM), .NUM_SLAVES(NS),
               .ERR_DATA(8'hFF), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .mstr_stb_i(mstr_stb), .mstr_we_i(mstr_we), .mstr_adr_i(mstr_adr), .mstr_dat_i(mstr_wdat),
    .mstr_ack_o(mstr_ack), .mstr_err_o(mstr_err), .mstr_dat_o(mstr_rdat),
    .bus_slv_addr_decode_value(dec_val), .bus_slv_addr_decode_mask(dec_mask),
    .slv_stb_o(slv_stb), .slv_we_o(slv_we), .slv_adr_o(slv_adr), .slv_dat_o(slv_wdat),
    .slv_ack_i(slv_ack), .slv_dat_i(slv_rdat),
    .grant_o(grant), .dbg_state_o(dbg_state)
  );

  // ---------------- slave responders ----------------
  // Each slave acks after wait_cfg[s] extra strobed cycles.
  int            wait_cfg[NS];
  int            stb_run[NS];
  logic [DW-1:0] rd_data[NS];

  always_comb begin
    slv_ack  = '0;
    slv_rdat = '0;
    for (int s = 0; s < NS; s++) begin
      slv_ack[NS-1-s]            = slv_stb[NS-1-s] && (stb_run[s] == wait_cfg[s]);
      slv_rdat[(NS-1-s)*DW +: DW] = rd_data[s];
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NS; s++) stb_run[s] <= 0;
    end else begin
      for (int s = 0; s < NS; s++)
        stb_run[s] <= (slv_stb[NS-1-s] && !slv_ack[NS-1-s]) ? stb_run[s] + 1 : 0;
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = -1;
  logic [DW-1:0] exp_q[$];

  bit            act[NM];
  bit            t_we[NM];
  logic [AW-1:0] t_adr[NM];
  logic [DW-1:0] t_dat[NM];
  int            f_wait[NM];
  int            f_rdat[NM];

  int rr_m = 0, idle_from = 0;
  int cur_m = -1, tgt = -1, g_from = 0, g_to = -1, stb_end = -1, resp_cyc = -1, ab_cyc = -1;
  bit resp_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Memory map in plain terms; lower slave number wins on overlap.
  function automatic int ref_slave(input logic [AW-1:0] a);
    if (a[15:8] == 8'h00)  return 0;
    if (a[15:12] == 4'h0)  return 1;
    if (a[15:12] == 4'hF)  return 2;
    return -1;
  endfunction

  function automatic bit any_act();
    bit r = 1'b0;
    for (int m = 0; m < NM; m++) r |= act[m];
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input int m, input bit we, input logic [AW-1:0] adr,
                       input logic [DW-1:0] dat, input int w, input int rd);
    act[m] = 1'b1; t_we[m] = we; t_adr[m] = adr; t_dat[m] = dat;
    f_wait[m] = w; f_rdat[m] = rd;
  endtask

  task automatic new_txn(input int m, input int mode);
    act[m] = 1'b1; t_dat[m] = DW'($urandom); f_wait[m] = -1; f_rdat[m] = -1;
    if (mode == 1) begin
      t_we[m] = 1'b0; t_adr[m] = 16'hF000 | AW'($urandom_range(0, 16'h0FFF)); f_wait[m] = 0;
    end else begin
      t_we[m] = bit'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0, 1, 2: t_adr[m] = {8'h00, 8'($urandom)};
        3, 4:    t_adr[m] = AW'($urandom_range(0, 16'h0FFF));
        5, 6, 7: t_adr[m] = 16'hF000 | AW'($urandom_range(0, 16'h0FFF));
        default: t_adr[m] = AW'($urandom);
      endcase
    end
  endtask

  // Decide the next transfer from the arbitration and decode rules and schedule its timeline.
  task automatic arbitrate();
    int m = -1;
    int w;
    bit forced;
    for (int k = 0; k < NM; k++) if (m < 0 && act[(rr_m + k) % NM]) m = (rr_m + k) % NM;
    forced = (f_wait[m] >= 0);
    cur_m = m; tgt = ref_slave(t_adr[m]); g_from = cyc + 1;
    ab_cyc = -1; resp_err = 1'b0; stb_end = -1;
    rr_m = (m + 1) % NM;
    if (tgt < 0) begin
      resp_err = 1'b1; resp_cyc = cyc + 2; g_to = resp_cyc;
      exp_q.push_back(8'hFF);
    end else begin
      w = forced ? f_wait[m] : int'($urandom_range(0, 3));
`ifdef WB_BUS_TIMEOUT_EN
      if (!forced && $urandom_range(0, 9) == 0) w = 99;
`endif
      wait_cfg[tgt] = w;
      rd_data[tgt]  = (f_rdat[m] >= 0) ? DW'(f_rdat[m]) : DW'($urandom);
      if (w >= TO) begin
        stb_end = g_from + TO - 1; resp_err = 1'b1; resp_cyc = g_from + TO; g_to = resp_cyc;
        exp_q.push_back(8'hFF);
      end else if (!forced && w > 0 && $urandom_range(0, 99) < 15) begin
        ab_cyc = g_from + int'($urandom_range(0, w - 1));
        stb_end = ab_cyc - 1; g_to = ab_cyc; resp_cyc = -1;
      end else begin
        resp_cyc = g_from + w; stb_end = resp_cyc; g_to = resp_cyc;
        exp_q.push_back(rd_data[tgt]);
      end
    end
    idle_from = (ab_cyc >= 0) ? ab_cyc + 1 : resp_cyc + 2;
    f_wait[m] = -1; f_rdat[m] = -1;
  endtask

  // One bus cycle: drive masters, run the model, then compare at posedge+3.
  task automatic cycle(input int mode);
    logic [NM-1:0] exp_g, exp_a, exp_e;
    logic [NS-1:0] exp_s;
    logic [DW-1:0] e;
    int sb;
    @(posedge clk); #1; cyc++;
    for (int m = 0; m < NM; m++) begin
      if (act[m] && cur_m == m && ab_cyc == cyc) act[m] = 1'b0;
      else if (!act[m] && mode > 0 && (mode == 1 || $urandom_range(0, 99) < 45)) new_txn(m, mode);
      mstr_stb[m] = act[m];
      mstr_we[m]  = t_we[m];
      mstr_adr[m*AW +: AW]  = t_adr[m];
      mstr_wdat[m*DW +: DW] = t_dat[m];
    end
    if (cyc >= idle_from && any_act()) arbitrate();
    #2;
    exp_g = '0; exp_s = '0; exp_a = '0; exp_e = '0;
    if (cur_m >= 0 && cyc >= g_from && cyc <= g_to) exp_g[cur_m] = 1'b1;
    if (cur_m >= 0 && tgt >= 0 && cyc >= g_from && cyc <= stb_end) exp_s[NS-1-tgt] = 1'b1;
    if (cur_m >= 0 && cyc == resp_cyc) begin
      if (resp_err) exp_e[cur_m] = 1'b1;
      else          exp_a[cur_m] = 1'b1;
    end
    check("grant", grant, exp_g);
    check("slv_stb", slv_stb, exp_s);
    check("mstr_ack", mstr_ack, exp_a);
    check("mstr_err", mstr_err, exp_e);
    check("rdat_known", $isunknown(mstr_rdat), 0);
    if (exp_s != '0) begin
      sb = NS - 1 - tgt;
      check("slv_adr", slv_adr[sb*AW +: AW], t_adr[cur_m]);
      check("slv_we", slv_we[sb], t_we[cur_m]);
      if (t_we[cur_m]) check("slv_wdat", slv_wdat[sb*DW +: DW], t_dat[cur_m]);
    end
    if (exp_a != '0 || exp_e != '0) begin
      e = exp_q.pop_front();
      check("mstr_rdat", mstr_rdat, e);
      act[cur_m] = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((any_act() || cyc < idle_from) && n < 60) begin
      cycle(0);
      n++;
    end
    if (n >= 60) check("drain_bound", n, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    mstr_stb = '0; mstr_we = '0; mstr_adr = '0; mstr_wdat = '0;
    for (int s = 0; s < NS; s++) begin wait_cfg[s] = 0; rd_data[s] = '0; end
    for (int m = 0; m < NM; m++) begin
      act[m] = 1'b0; t_we[m] = 1'b0; t_adr[m] = '0; t_dat[m] = '0; f_wait[m] = -1; f_rdat[m] = -1;
    end
    repeat (3) @(posedge clk);
    #3;
    check("rst_grant", grant, 0);
    check("rst_slv_stb", slv_stb, 0);
    check("rst_ack", mstr_ack, 0);
    check("rst_err", mstr_err, 0);
    @(negedge clk); rst_n = 1'b1;

    issue(0, 1'b0, 16'hF010, 8'h00, 0, 8'hA9); drain();   // ROM read
    issue(0, 1'b1, 16'h0085, 8'h55, 0, 8'h00); drain();   // RAM write, overlap with slave 1
    issue(1, 1'b0, 16'h1234, 8'h00, 0, 8'h00); drain();   // unmapped
    issue(1, 1'b0, 16'h0500, 8'h00, 2, 8'h5A); drain();   // slave 1, two wait states
    repeat (30) cycle(1);                                 // back-to-back from both masters
    drain();
    repeat (1500) cycle(2);
    drain();
    check("exp_q_left", exp_q.size(), 0);

    // Leave the pointer at master 1, then reset while master 1 is mid-transfer.
    issue(0, 1'b0, 16'hF000, 8'h00, 0, 8'h3C); drain();
    issue(1, 1'b0, 16'h0500, 8'h00, 50, 8'h00);
    cycle(0);
    cycle(0);
    @(posedge clk); #4;
    rst_n = 1'b0;
    #1;
    check("arst_grant", grant, 0);
    check("arst_slv_stb", slv_stb, 0);
    check("arst_ack", mstr_ack, 0);
    check("arst_err", mstr_err, 0);
    mstr_stb = 2'b11; mstr_we = 2'b00; mstr_adr = {16'hF000, 16'hF000};
    wait_cfg[2] = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #2;
    check("first_grant_after_rst", grant, 2'b01);

    $display("test done: total=%0d bad=%0d", n_cmp, n_bad);
    $finish;
  end

endmodule
